// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared types and sizing for the bit-serial subtractor (sub_pkg).
// The optional signed-overflow output is enabled by defining SUB_OVF_EN.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_e;

   localparam int SUB_WIDTH_DEF = 4;
   localparam int SUB_CNT_W     = $clog2(SUB_WIDTH_DEF + 1);

   // Counter must be able to hold WIDTH itself, hence +1.
   function automatic int sub_cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_subtractor_4bit_if.sv
// Handshake and operand/result bundle for serial_subtractor_4bit.
// The ovf signal and its modport entries exist only when SUB_OVF_EN is defined.
interface serial_subtractor_4bit_if
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             b_out;
`ifdef SUB_OVF_EN
   logic             ovf;

   modport master (
      output start, x, y, b_in,
      input  busy, done, diff, b_out, ovf
   );

   modport slave (
      input  start, x, y, b_in,
      output busy, done, diff, b_out, ovf
   );
`else
   modport master (
      output start, x, y, b_in,
      input  busy, done, diff, b_out
   );

   modport slave (
      input  start, x, y, b_in,
      output busy, done, diff, b_out
   );
`endif

endinterface

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bi, bo = borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: x - y - b_in resolved LSB-first through one full_subtractor cell.
// Defining SUB_OVF_EN adds a registered signed-overflow flag (ovf).
module serial_subtractor_4bit
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   serial_subtractor_4bit_if.slave sub_bus
);

   localparam int               CNT_W    = sub_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   sub_state_e       state_q,  state_d;
   logic [WIDTH-1:0] x_q,      x_d;
   logic [WIDTH-1:0] y_q,      y_d;
   logic [WIDTH-1:0] res_q,    res_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             b_out_q,  b_out_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
`ifdef SUB_OVF_EN
   logic             ovf_q,    ovf_d;
`endif

   logic             d_bit_s;
   logic             bo_s;

   full_subtractor u_fs (
      .a  (x_q[0]),
      .b  (y_q[0]),
      .bi (borrow_q),
      .d  (d_bit_s),
      .bo (bo_s)
   );

   // Next-state, datapath and output-register decode
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      b_out_d  = b_out_q;
`ifdef SUB_OVF_EN
      ovf_d    = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (sub_bus.start) begin
               x_d      = sub_bus.x;
               y_d      = sub_bus.y;
               borrow_d = sub_bus.b_in;
               res_d    = {WIDTH{1'b0}};
               cnt_d    = {CNT_W{1'b0}};
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            x_d      = x_q >> 1;
            y_d      = y_q >> 1;
            res_d    = {d_bit_s, res_q[WIDTH-1:1]};
            borrow_d = bo_s;
            cnt_d    = cnt_q + CNT_W'(1);
            // The final bit is still in flight, so publish from the cell directly.
            if (cnt_q == LAST_CNT) begin
               diff_d  = {d_bit_s, res_q[WIDTH-1:1]};
               b_out_d = bo_s;
`ifdef SUB_OVF_EN
               ovf_d   = borrow_q ^ bo_s;
`endif
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         x_q      <= {WIDTH{1'b0}};
         y_q      <= {WIDTH{1'b0}};
         res_q    <= {WIDTH{1'b0}};
         borrow_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         diff_q   <= {WIDTH{1'b0}};
         b_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         b_out_q  <= b_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SUB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign sub_bus.busy  = busy_q;
   assign sub_bus.done  = done_q;
   assign sub_bus.diff  = diff_q;
   assign sub_bus.b_out = b_out_q;
`ifdef SUB_OVF_EN
   assign sub_bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit: vector table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_serial_subtractor_4bit;
   import sub_pkg::*;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] xv;
      logic [W-1:0] yv;
      logic         bv;
      logic [W-1:0] ediff;
      logic         ebout;
   } vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   serial_subtractor_4bit_if #(.WIDTH(W)) bus ();

   serial_subtractor_4bit #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sub_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Reference from plain integer arithmetic: returns {ovf, b_out, diff}
   function automatic logic [W+1:0] ref_sub(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic bv);
      int u;
      int s;
      logic [W-1:0] d;
      logic bo;
      logic ov;
      u  = int'(xv) - int'(yv) - int'(bv);
      s  = int'($signed(xv)) - int'($signed(yv)) - int'(bv);
      d  = W'(u);
      bo = (u < 0);
      ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
      return {ov, bo, d};
   endfunction

   task automatic do_op(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                        input logic bv, input logic [W-1:0] ediff, input logic ebout);
      int k;
      int busy_n;
      logic [W+1:0] r;
      r = ref_sub(xv, yv, bv);
      @(negedge clk);
      bus.start = 1'b1; bus.x = xv; bus.y = yv; bus.b_in = bv;
      @(negedge clk);
      bus.start = 1'b0; bus.x = W'($urandom); bus.y = W'($urandom); bus.b_in = 1'($urandom);
      k = 1; busy_n = 0;
      while (!bus.done && k < 20) begin
         busy_n += int'(bus.busy);
         @(negedge clk);
         k++;
      end
      check({name, "_latency"}, k - 1, W);
      check({name, "_busy_cycles"}, busy_n, W);
      check({name, "_diff"}, bus.diff, ediff);
      check({name, "_b_out"}, bus.b_out, ebout);
      check({name, "_busy_at_done"}, bus.busy, 1'b0);
`ifdef SUB_OVF_EN
      check({name, "_ovf"}, bus.ovf, r[W+1]);
`endif
      @(negedge clk);
      check({name, "_done_single"}, bus.done, 1'b0);
   endtask

   initial begin
      vec_t tbl[6];
      int k;
      int ndone;
      logic [W-1:0] xs[20];
      logic [W-1:0] ys[20];
      logic         bs[20];
      logic [W+1:0] r;
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      logic         rb;

      checks = 0; failures = 0;
      tbl[0] = '{4'd9,  4'd2,  1'b0, 4'd7,  1'b0};
      tbl[1] = '{4'd2,  4'd9,  1'b0, 4'd9,  1'b1};
      tbl[2] = '{4'd0,  4'd0,  1'b1, 4'd15, 1'b1};
      tbl[3] = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0};
      tbl[4] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
      tbl[5] = '{4'd15, 4'd0,  1'b0, 4'd15, 1'b0};

      rst_n = 1'b0; bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.b_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_diff", bus.diff, 0);
      check("reset_b_out", bus.b_out, 1'b0);
`ifdef SUB_OVF_EN
      check("reset_ovf", bus.ovf, 1'b0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 6; i++)
         do_op($sformatf("vec%0d", i), tbl[i].xv, tbl[i].yv, tbl[i].bv, tbl[i].ediff, tbl[i].ebout);

      // start re-asserted during SHIFT must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.x = 4'd5; bus.y = 4'd3; bus.b_in = 1'b0;
      @(negedge clk);
      bus.x = 4'd15; bus.y = 4'd0;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      k = 3;
      while (!bus.done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("ignore_latency", k - 1, W);
      check("ignore_diff", bus.diff, 4'd2);
      check("ignore_b_out", bus.b_out, 1'b0);
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         ndone += int'(bus.done);
      end
      check("ignore_no_second_done", ndone, 0);
      check("ignore_diff_hold", bus.diff, 4'd2);

      // asynchronous reset after two shift cycles
      @(negedge clk);
      bus.start = 1'b1; bus.x = 4'd12; bus.y = 4'd4; bus.b_in = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_diff", bus.diff, 0);
      check("midrst_b_out", bus.b_out, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         ndone += int'(bus.done);
      end
      check("midrst_no_done", ndone, 0);
      do_op("fresh", 4'd12, 4'd4, 1'b0, 4'd8, 1'b0);

      // start held high: captures only on IDLE edges, one result every W+2 cycles
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         xs[c] = W'($urandom); ys[c] = W'($urandom); bs[c] = 1'($urandom);
         bus.start = 1'b1; bus.x = xs[c]; bus.y = ys[c]; bus.b_in = bs[c];
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            check("b2b_done_edge", c % (W + 2), W);
            if (c >= W) begin
               r = ref_sub(xs[c-W], ys[c-W], bs[c-W]);
               check("b2b_diff", bus.diff, r[W-1:0]);
               check("b2b_b_out", bus.b_out, r[W]);
`ifdef SUB_OVF_EN
               check("b2b_ovf", bus.ovf, r[W+1]);
`endif
            end
         end
      end
      bus.start = 1'b0;
      check("b2b_done_count", ndone, 3);
      repeat (10) @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         rx = W'($urandom); ry = W'($urandom); rb = 1'($urandom);
         r  = ref_sub(rx, ry, rb);
         do_op("rand", rx, ry, rb, r[W-1:0], r[W]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
